rom_stream: RTL and testbench

Parametrised ROM playback engine. It holds a constant table in block RAM and, on command, streams a contiguous run of words out through a valid/ready interface. This generalises the plain addressed ROM: instead of the consumer driving addresses, the block generates them itself, honours backpressure, wraps around, and optionally loops. It sits between constant tables (waveforms, init sequences, microcode) and streaming consumers such as serialisers, DAC drivers and command FIFOs.

---
 rtl/rom_stream_if.sv | 32 +++
 rtl/rom_stream.sv | 160 ++++++++++++++++
 tb/tb_rom_stream.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_if.sv
// Command and stream signals of rom_stream grouped into one interface.
// The loop signal exists only when ROM_STREAM_LOOP_EN is defined.
interface rom_stream_if #(
  parameter int AW = 8,
  parameter int n  = 8
);
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
`ifdef ROM_STREAM_LOOP_EN
  logic          loop;
`endif
  logic          abort;
  logic          ready;
  logic          valid;
  logic [n-1:0]  data_o;
  logic          last;
  logic          busy;
  logic          done;

`ifdef ROM_STREAM_LOOP_EN
  modport master (output start, start_addr, count, loop, abort, ready,
                  input  valid, data_o, last, busy, done);
  modport slave  (input  start, start_addr, count, loop, abort, ready,
                  output valid, data_o, last, busy, done);
`else
  modport master (output start, start_addr, count, abort, ready,
                  input  valid, data_o, last, busy, done);
  modport slave  (input  start, start_addr, count, abort, ready,
                  output valid, data_o, last, busy, done);
`endif
endinterface

// File: rtl/rom_stream.sv
// ROM playback engine: streams a contiguous, wrapping run of constant words over valid/ready.
// Optional repeat-forever behaviour is enabled by defining ROM_STREAM_LOOP_EN.
//
// state | meaning
// IDLE  | waiting for start; done pulse is emitted from here
// RUN   | words are loaded from the ROM and handed out under backpressure
module rom_stream #(
  parameter int m            = 256,
  parameter int n            = 8,
  parameter int content_size = m,
  parameter logic [content_size*n-1:0] data = '0
) (
  input  logic clk,
  input  logic rst,
  rom_stream_if.slave bus
);
  localparam int AW = (m > 1) ? $clog2(m) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_d;
  logic [AW-1:0] ptr, ptr_d, ptr_inc;
  logic [AW:0]   rem, rem_d;
  logic [AW-1:0] sa_q, sa_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [n-1:0]  data_q;
  logic          load;
  logic          xfer;
  logic          loop_q;
`ifdef ROM_STREAM_LOOP_EN
  logic          loop_d;
`endif

  // Constant table; words beyond content_size read as zero.
  logic [n-1:0] rom [m];
  for (genvar i = 0; i < m; i++) begin : g_rom
    if (i < content_size) begin : g_init
      assign rom[i] = data[(content_size-1-i)*n +: n];
    end else begin : g_zero
      assign rom[i] = '0;
    end
  end

  // Explicit compare so non-power-of-two depths wrap correctly.
  assign ptr_inc = (ptr == AW'(m - 1)) ? '0 : ptr + 1'b1;
  assign xfer    = valid_q && bus.ready;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    rem_d   = rem;
    sa_d    = sa_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef ROM_STREAM_LOOP_EN
    loop_d  = loop_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            ptr_d   = bus.start_addr;
            rem_d   = bus.count;
            sa_d    = bus.start_addr;
            cnt_d   = bus.count;
`ifdef ROM_STREAM_LOOP_EN
            loop_d  = bus.loop;
`endif
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (xfer && last_q && !loop_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if ((rem != '0) && (!valid_q || bus.ready)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          last_d  = (rem == (AW+1)'(1));
          // Reloading on the final load of a pass keeps loop passes gap-free.
          if ((rem == (AW+1)'(1)) && loop_q) begin
            ptr_d = sa_q;
            rem_d = cnt_q;
          end else begin
            ptr_d = ptr_inc;
            rem_d = rem - 1'b1;
          end
        end else if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      rem     <= '0;
      sa_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      rem     <= rem_d;
      sa_q    <= sa_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Synchronous read straight into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= rom[ptr];
    end
  end

`ifdef ROM_STREAM_LOOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q <= 1'b0;
    end else begin
      loop_q <= loop_d;
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  assign bus.valid  = valid_q;
  assign bus.data_o = data_q;
  assign bus.last   = last_q;
  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
endmodule

// File: tb/tb_rom_stream.sv
// Self-checking bench for rom_stream (m=8, n=4, six initialised words 0..5).
// The looping scenario is exercised only when ROM_STREAM_LOOP_EN is defined.
module tb_rom_stream;
  localparam int M   = 8;
  localparam int N   = 4;
  localparam int CS  = 6;
  localparam int AWL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_stream_if #(.AW(AWL), .n(N)) bus();

  rom_stream #(.m(M), .n(N), .content_size(CS), .data(24'h012345)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int sa;
    int cnt;
    int pct;
    int first_w;
    int last_w;
    int len;
  } vec_t;

  vec_t tbl[6];

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Reference contents: word i holds value i for the initialised words, zero beyond.
  function automatic int rom_model(int a);
    return (a < CS) ? a : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sa, input int cnt);
    bus.start_addr = AWL'(sa);
    bus.count      = (AWL+1)'(cnt);
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  // Consumes one run with random backpressure and compares against the model.
  task automatic collect(input int sa, input int cnt, input int pct, input string tag,
                         output int first_w, output int last_w, output int n_got);
    int  got  = 0;
    bit  held = 0;
    int  hd   = 0;
    int  hl   = 0;
    first_w = -1;
    last_w  = -1;
    for (int cyc = 0; cyc < 300 && got < cnt; cyc++) begin
      bus.ready = ($urandom_range(0, 99) < pct);
      check({tag, "_no_early_done"}, int'(bus.done), 0);
      if (held) begin
        check({tag, "_hold_valid"}, int'(bus.valid), 1);
        check({tag, "_hold_data"}, int'(bus.data_o), hd);
        check({tag, "_hold_last"}, int'(bus.last), hl);
      end
      held = 0;
      if (bus.valid && bus.ready) begin
        check({tag, "_data"}, int'(bus.data_o), rom_model((sa + got) % M));
        check({tag, "_last"}, int'(bus.last), (got == cnt - 1) ? 1 : 0);
        if (got == 0) first_w = int'(bus.data_o);
        last_w = int'(bus.data_o);
        got++;
      end else if (bus.valid) begin
        held = 1;
        hd   = int'(bus.data_o);
        hl   = int'(bus.last);
      end
      step();
      bus.start = 1'b0;
    end
    n_got = got;
    check({tag, "_word_count"}, got, cnt);
    check({tag, "_done_pulse"}, int'(bus.done), 1);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
    check({tag, "_valid_end"}, int'(bus.valid), 0);
    bus.ready = 1'b0;
    step();
    check({tag, "_done_drop"}, int'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fw, lw, ng;
    int exp_v[6];
    int exp_d[6];
    int exp_l[6];
    int exp_b[6];
    int exp_dn[6];

    tbl[0] = '{1, 3, 100, 1, 3, 3};
    tbl[1] = '{4, 5, 100, 4, 0, 5};
    tbl[2] = '{7, 1, 50,  0, 0, 1};
    tbl[3] = '{0, 8, 60,  0, 0, 8};
    tbl[4] = '{5, 1, 100, 5, 5, 1};
    tbl[5] = '{6, 4, 70,  0, 1, 4};

    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.abort      = 1'b0;
    bus.ready      = 1'b0;
`ifdef ROM_STREAM_LOOP_EN
    bus.loop       = 1'b0;
`endif
    rst = 1'b1;
    step();
    step();
    check("rst_valid", int'(bus.valid), 0);
    check("rst_data", int'(bus.data_o), 0);
    check("rst_last", int'(bus.last), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    step();

    // Basic run cycle by cycle: two-cycle latency, last on word 3, done one cycle later.
    exp_v  = '{0, 1, 1, 1, 0, 0};
    exp_d  = '{0, 1, 2, 3, 3, 3};
    exp_l  = '{0, 0, 0, 1, 0, 0};
    exp_b  = '{1, 1, 1, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 1, 0};
    bus.ready = 1'b1;
    issue(1, 3);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("basic_valid_c%0d", k), int'(bus.valid), exp_v[k]);
      if (exp_v[k] == 1) check($sformatf("basic_data_c%0d", k), int'(bus.data_o), exp_d[k]);
      check($sformatf("basic_last_c%0d", k), int'(bus.last), exp_l[k]);
      check($sformatf("basic_busy_c%0d", k), int'(bus.busy), exp_b[k]);
      check($sformatf("basic_done_c%0d", k), int'(bus.done), exp_dn[k]);
      step();
    end

    // Backpressure: word 2 held for three stalled cycles.
    bus.ready = 1'b1;
    issue(1, 3);
    step();
    check("bp_first", int'(bus.data_o), 1);
    step();
    check("bp_second", int'(bus.data_o), 2);
    bus.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_valid_%0d", k), int'(bus.valid), 1);
      check($sformatf("bp_hold_data_%0d", k), int'(bus.data_o), 2);
      check($sformatf("bp_hold_last_%0d", k), int'(bus.last), 0);
    end
    bus.ready = 1'b1;
    step();
    check("bp_third", int'(bus.data_o), 3);
    check("bp_third_last", int'(bus.last), 1);
    step();
    check("bp_done", int'(bus.done), 1);
    check("bp_busy", int'(bus.busy), 0);
    step();

    // Table-driven runs, including wrap and full-depth.
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].sa, tbl[i].cnt);
      collect(tbl[i].sa, tbl[i].cnt, tbl[i].pct, $sformatf("tbl%0d", i), fw, lw, ng);
      check($sformatf("tbl%0d_first", i), fw, tbl[i].first_w);
      check($sformatf("tbl%0d_lastw", i), lw, tbl[i].last_w);
      check($sformatf("tbl%0d_len", i), ng, tbl[i].len);
    end

    // count == 0: done next cycle, nothing emitted.
    issue(3, 0);
    check("zero_done", int'(bus.done), 1);
    check("zero_valid", int'(bus.valid), 0);
    check("zero_busy", int'(bus.busy), 0);
    step();
    check("zero_done_drop", int'(bus.done), 0);
    check("zero_valid2", int'(bus.valid), 0);

    // start held into RUN with a different command must be ignored.
    issue(0, 2);
    bus.start      = 1'b1;
    bus.start_addr = AWL'(5);
    bus.count      = (AWL+1)'(1);
    collect(0, 2, 100, "ignore", fw, lw, ng);

    // Abort mid-run.
    bus.ready = 1'b1;
    issue(0, 5);
    step();
    step();
    check("abort_pre_valid", int'(bus.valid), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_valid", int'(bus.valid), 0);
    check("abort_last", int'(bus.last), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    step();
    check("abort_done2", int'(bus.done), 0);

    // Abort coincident with start in IDLE has no effect.
    bus.abort = 1'b1;
    issue(2, 1);
    bus.abort = 1'b0;
    collect(2, 1, 100, "abort_idle", fw, lw, ng);

    // Reset mid-run, then a single-word run.
    bus.ready = 1'b1;
    issue(0, 6);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", int'(bus.valid), 0);
    check("mrst_data", int'(bus.data_o), 0);
    check("mrst_last", int'(bus.last), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    issue(5, 1);
    collect(5, 1, 100, "post_rst", fw, lw, ng);
    check("post_rst_word", fw, 5);

`ifdef ROM_STREAM_LOOP_EN
    // Looping pass of two words: 0,1,0,1,0 without gaps, then abort.
    bus.ready = 1'b1;
    bus.loop  = 1'b1;
    issue(0, 2);
    bus.loop  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("loop_valid_%0d", k), int'(bus.valid), 1);
      check($sformatf("loop_data_%0d", k), int'(bus.data_o), rom_model(k % 2));
      check($sformatf("loop_last_%0d", k), int'(bus.last), (k % 2 == 1) ? 1 : 0);
      check($sformatf("loop_done_%0d", k), int'(bus.done), 0);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("loop_abort_valid", int'(bus.valid), 0);
    check("loop_abort_busy", int'(bus.busy), 0);
    check("loop_abort_done", int'(bus.done), 0);
    step();
    check("loop_abort_done2", int'(bus.done), 0);
`endif

    // Randomised back-to-back runs against the model.
    for (int i = 0; i < 20; i++) begin
      int sa, cnt, pct;
      sa  = int'($urandom_range(0, M - 1));
      cnt = int'($urandom_range(1, M));
      pct = int'($urandom_range(30, 100));
      issue(sa, cnt);
      collect(sa, cnt, pct, $sformatf("rnd%0d", i), fw, lw, ng);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
